// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID/EX pipeline register of a 5-stage MIPS pipeline, with load-use
//   hazard detection and a saturating count of inserted load-use bubbles.
//
//   Ports
//     clk, rst                 clock, async active-high reset
//     ID_Valid                 ID holds a real instruction
//     ID_Order                 instruction word (rs/rt/rd/imm fields)
//     ID_ReadData1/2           register file data for rs / rt
//     ID_UsesRt                ID instruction reads rt as a source
//     ID_ZeroExt               zero- (1) or sign- (0) extend imm
//     ID_Ctrl                  {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,RegDst,ALUOp[1:0]}
//     ID_Flush                 squash the ID instruction
//     EX_Hold                  downstream stall, freeze ID/EX
//     ID_Stall                 hold PC and IF/ID (combinational)
//     EX_*                     latched stage contents
//     EX_BubbleCnt             saturating count of load-use bubbles
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_Valid,
  input  logic [31:0]      ID_Order,
  input  logic [31:0]      ID_ReadData1,
  input  logic [31:0]      ID_ReadData2,
  input  logic             ID_UsesRt,
  input  logic             ID_ZeroExt,
  input  logic [7:0]       ID_Ctrl,
  input  logic             ID_Flush,
  input  logic             EX_Hold,
  output logic             ID_Stall,
  output logic             EX_Valid,
  output logic [31:0]      EX_ReadData1,
  output logic [31:0]      EX_ReadData2,
  output logic [31:0]      EX_Imm,
  output logic [4:0]       EX_Rs,
  output logic [4:0]       EX_Rt,
  output logic [4:0]       EX_WriteReg,
  output logic [7:0]       EX_Ctrl,
  output logic [CNT_W-1:0] EX_BubbleCnt
);

  localparam int CTRL_MEMREAD = 6;
  localparam int CTRL_REGDST  = 2;

  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [15:0] id_imm;
  logic [31:0] id_imm_ext;
  logic        load_use;
  logic        bubble;
  logic        unused_opcode;

  assign id_rs  = ID_Order[25:21];
  assign id_rt  = ID_Order[20:16];
  assign id_rd  = ID_Order[15:11];
  assign id_imm = ID_Order[15:0];
  assign unused_opcode = &{1'b0, ID_Order[31:26]};

  assign id_imm_ext = ID_ZeroExt ? {16'h0000, id_imm} : {{16{id_imm[15]}}, id_imm};

  // A load in EX whose destination is read by ID must wait one cycle; $0 is
  // hardwired to zero so a load targeting it can never be a hazard.
  assign load_use = EX_Valid & EX_Ctrl[CTRL_MEMREAD] & ID_Valid &
                    (EX_WriteReg != 5'd0) &
                    ((EX_WriteReg == id_rs) | (ID_UsesRt & (EX_WriteReg == id_rt)));

  assign ID_Stall = load_use | EX_Hold;
  assign bubble   = ID_Flush | load_use;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      EX_Valid     <= 1'b0;
      EX_ReadData1 <= '0;
      EX_ReadData2 <= '0;
      EX_Imm       <= '0;
      EX_Rs        <= '0;
      EX_Rt        <= '0;
      EX_WriteReg  <= '0;
      EX_Ctrl      <= '0;
    end else if (EX_Hold) begin
      // keep everything
    end else if (bubble) begin
      EX_Valid     <= 1'b0;
      EX_ReadData1 <= '0;
      EX_ReadData2 <= '0;
      EX_Imm       <= '0;
      EX_Rs        <= '0;
      EX_Rt        <= '0;
      EX_WriteReg  <= '0;
      EX_Ctrl      <= '0;
    end else begin
      EX_Valid     <= ID_Valid;
      EX_ReadData1 <= ID_ReadData1;
      EX_ReadData2 <= ID_ReadData2;
      EX_Imm       <= id_imm_ext;
      EX_Rs        <= id_rs;
      EX_Rt        <= id_rt;
      EX_WriteReg  <= ID_Ctrl[CTRL_REGDST] ? id_rd : id_rt;
      EX_Ctrl      <= ID_Valid ? ID_Ctrl : 8'h00;
    end
  end

  // Only load-use bubbles are counted; a flush in the same cycle owns the bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      EX_BubbleCnt <= '0;
    end else if (!EX_Hold && load_use && !ID_Flush && (EX_BubbleCnt != {CNT_W{1'b1}})) begin
      EX_BubbleCnt <= EX_BubbleCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ID_Valid = 1'b0;
  logic [31:0] ID_Order = '0;
  logic [31:0] ID_ReadData1 = '0;
  logic [31:0] ID_ReadData2 = '0;
  logic        ID_UsesRt = 1'b0;
  logic        ID_ZeroExt = 1'b0;
  logic [7:0]  ID_Ctrl = '0;
  logic        ID_Flush = 1'b0;
  logic        EX_Hold = 1'b0;

  logic        w_stall, w_valid;
  logic [31:0] w_rd1, w_rd2, w_imm;
  logic [4:0]  w_rs, w_rt, w_wr;
  logic [7:0]  w_ctrl;
  logic [15:0] w_cnt;

  logic        n_stall, n_valid;
  logic [31:0] n_rd1, n_rd2, n_imm;
  logic [4:0]  n_rs, n_rt, n_wr;
  logic [7:0]  n_ctrl;
  logic [1:0]  n_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.CNT_W(16)) dut_wide (
    .clk(clk), .rst(rst), .ID_Valid(ID_Valid), .ID_Order(ID_Order),
    .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
    .ID_UsesRt(ID_UsesRt), .ID_ZeroExt(ID_ZeroExt), .ID_Ctrl(ID_Ctrl),
    .ID_Flush(ID_Flush), .EX_Hold(EX_Hold), .ID_Stall(w_stall),
    .EX_Valid(w_valid), .EX_ReadData1(w_rd1), .EX_ReadData2(w_rd2),
    .EX_Imm(w_imm), .EX_Rs(w_rs), .EX_Rt(w_rt), .EX_WriteReg(w_wr),
    .EX_Ctrl(w_ctrl), .EX_BubbleCnt(w_cnt)
  );

  id_ex_stage #(.CNT_W(2)) dut_narrow (
    .clk(clk), .rst(rst), .ID_Valid(ID_Valid), .ID_Order(ID_Order),
    .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
    .ID_UsesRt(ID_UsesRt), .ID_ZeroExt(ID_ZeroExt), .ID_Ctrl(ID_Ctrl),
    .ID_Flush(ID_Flush), .EX_Hold(EX_Hold), .ID_Stall(n_stall),
    .EX_Valid(n_valid), .EX_ReadData1(n_rd1), .EX_ReadData2(n_rd2),
    .EX_Imm(n_imm), .EX_Rs(n_rs), .EX_Rt(n_rt), .EX_WriteReg(n_wr),
    .EX_Ctrl(n_ctrl), .EX_BubbleCnt(n_cnt)
  );

  // Reference model: what EX should hold, and how many load-use bubbles so far.
  typedef struct {
    bit        valid;
    bit [31:0] rd1, rd2, imm;
    bit [4:0]  rs, rt, wr;
    bit [7:0]  ctrl;
  } ex_t;

  typedef struct {
    ex_t         st;
    bit          stall;
    int unsigned cnt;
  } exp_t;

  ex_t         m;
  int unsigned m_cnt;
  exp_t        sb[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m = '{default: '0};
    m_cnt = 0;
  endtask

  // Drive one ID cycle at the falling edge and queue the expected outcome.
  task automatic step(input bit v, input bit [31:0] ord, input bit urt, input bit zx,
                      input bit [7:0] c, input bit fl, input bit hd);
    exp_t e;
    bit hz;
    bit [31:0] d1, d2;
    @(negedge clk);
    d1 = $urandom;
    d2 = $urandom;
    ID_Valid = v; ID_Order = ord; ID_UsesRt = urt; ID_ZeroExt = zx;
    ID_Ctrl = c; ID_Flush = fl; EX_Hold = hd;
    ID_ReadData1 = d1; ID_ReadData2 = d2;
    hz = m.valid && m.ctrl[6] && v && (m.wr != 0) &&
         ((m.wr == ord[25:21]) || (urt && (m.wr == ord[20:16])));
    e.stall = hz || hd;
    if (hd) begin
      // unchanged
    end else if (fl || hz) begin
      m = '{default: '0};
      if (!fl) m_cnt++;
    end else begin
      m.valid = v;
      m.ctrl  = v ? c : 8'h00;
      m.rd1   = d1;
      m.rd2   = d2;
      m.imm   = zx ? {16'h0000, ord[15:0]} : {{16{ord[15]}}, ord[15:0]};
      m.rs    = ord[25:21];
      m.rt    = ord[20:16];
      m.wr    = c[2] ? ord[15:11] : ord[20:16];
    end
    e.st  = m;
    e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  // Monitor: sample the combinational stall mid-low-phase, compare EX after the edge.
  initial begin : monitor
    exp_t e;
    logic ws, ns;
    forever begin
      @(negedge clk);
      #2;
      ws = w_stall;
      ns = n_stall;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stall",    {31'b0, ws},      {31'b0, e.stall});
        chk("stall_n",  {31'b0, ns},      {31'b0, e.stall});
        chk("valid",    {31'b0, w_valid}, {31'b0, e.st.valid});
        chk("ctrl",     {24'b0, w_ctrl},  {24'b0, e.st.ctrl});
        chk("rd1",      w_rd1,            e.st.rd1);
        chk("rd2",      w_rd2,            e.st.rd2);
        chk("imm",      w_imm,            e.st.imm);
        chk("rs",       {27'b0, w_rs},    {27'b0, e.st.rs});
        chk("rt",       {27'b0, w_rt},    {27'b0, e.st.rt});
        chk("wr",       {27'b0, w_wr},    {27'b0, e.st.wr});
        chk("cnt_wide", {16'b0, w_cnt},   sat(e.cnt, 65535));
        chk("cnt_narrow", {30'b0, n_cnt}, sat(e.cnt, 3));
        chk("valid_n",  {31'b0, n_valid}, {31'b0, e.st.valid});
        chk("wr_n",     {27'b0, n_wr},    {27'b0, e.st.wr});
      end
    end
  end

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 10) begin
      @(posedge clk);
      k++;
    end
    chk("drain", sb.size(), 0);
    @(posedge clk);
    #2;
  endtask

  localparam bit [7:0] C_LW  = 8'hD8;  // RegWrite MemRead MemtoReg ALUSrc
  localparam bit [7:0] C_ADD = 8'h86;  // RegWrite RegDst ALUOp=10
  localparam bit [31:0] LW_2   = 32'h8C22FFFC;  // lw $2,-4($1)
  localparam bit [31:0] LW_0   = 32'h8C200000;  // lw $0,0($1)
  localparam bit [31:0] ADD_32 = 32'h00441820;  // add $3,$2,$4
  localparam bit [31:0] ADD_00 = 32'h00001820;  // add $3,$0,$0
  localparam bit [31:0] RT_ONLY = 32'h00A21820; // rs=5, rt=2

  initial begin : stim
    bit [31:0] ord;
    bit [15:0] imm;
    model_reset();
    #3;
    chk("rst_valid", {31'b0, w_valid}, 32'd0);
    chk("rst_cnt",   {16'b0, w_cnt},   32'd0);
    chk("rst_stall", {31'b0, w_stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Capture, sign- then zero-extended immediate.
    step(1, LW_2, 0, 0, C_LW, 0, 0);
    @(posedge clk); #2;
    chk("cap_imm_sx", w_imm, 32'hFFFFFFFC);
    chk("cap_wr",     {27'b0, w_wr}, 32'd2);
    chk("cap_rs",     {27'b0, w_rs}, 32'd1);
    step(1, LW_2, 0, 1, C_LW, 0, 0);
    @(posedge clk); #2;
    chk("cap_imm_zx", w_imm, 32'h0000FFFC);

    // Load-use: one stall, one bubble, then the add goes through.
    step(1, ADD_32, 1, 0, C_ADD, 0, 0);
    #1 chk("lu_stall", {31'b0, w_stall}, 32'd1);
    @(posedge clk); #2;
    chk("lu_bubble", {31'b0, w_valid}, 32'd0);
    chk("lu_cnt",    {16'b0, w_cnt},   32'd1);
    step(1, ADD_32, 1, 0, C_ADD, 0, 0);
    #1 chk("lu_release", {31'b0, w_stall}, 32'd0);
    @(posedge clk); #2;
    chk("lu_capture", {27'b0, w_wr}, 32'd3);

    // No hazard: load to $0, and rt-only match when rt is not a source.
    step(1, LW_0, 0, 0, C_LW, 0, 0);
    step(1, ADD_00, 1, 0, C_ADD, 0, 0);
    #1 chk("nohz_r0", {31'b0, w_stall}, 32'd0);
    step(1, LW_2, 0, 0, C_LW, 0, 0);
    step(1, RT_ONLY, 0, 0, C_ADD, 0, 0);
    #1 chk("nohz_rt", {31'b0, w_stall}, 32'd0);

    // Flush together with load-use: single bubble, count unchanged.
    step(1, LW_2, 0, 0, C_LW, 0, 0);
    step(1, ADD_32, 1, 0, C_ADD, 1, 0);
    @(posedge clk); #2;
    chk("fl_cnt", {16'b0, w_cnt}, 32'd1);

    // Hold beats flush.
    step(1, LW_2, 0, 1, C_LW, 0, 0);
    step(1, ADD_32, 1, 0, C_ADD, 1, 1);
    #1 chk("hold_stall", {31'b0, w_stall}, 32'd1);
    @(posedge clk); #2;
    chk("hold_imm", w_imm, 32'h0000FFFC);
    step(0, 32'h0, 0, 0, 8'h00, 0, 0);
    drain();

    // Mid-cycle reset with a real instruction in EX.
    step(1, LW_2, 0, 0, C_LW, 0, 0);
    drain();
    chk("pre_rst_valid", {31'b0, w_valid}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mrst_valid", {31'b0, w_valid}, 32'd0);
    chk("mrst_ctrl",  {24'b0, w_ctrl},  32'd0);
    chk("mrst_rd1",   w_rd1,            32'd0);
    chk("mrst_imm",   w_imm,            32'd0);
    chk("mrst_cnt",   {16'b0, w_cnt},   32'd0);
    chk("mrst_stall", {31'b0, w_stall}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Five load-use bubbles: narrow counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      step(1, LW_2, 0, 0, C_LW, 0, 0);
      step(1, ADD_32, 1, 0, C_ADD, 0, 0);
    end
    drain();
    chk("sat_narrow", {30'b0, n_cnt}, 32'd3);
    chk("sat_wide",   {16'b0, w_cnt}, 32'd5);

    // Random traffic with small register numbers to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      imm = 16'($urandom);
      if ($urandom_range(1, 0) == 1) imm[15:13] = 3'b000;
      ord = {6'($urandom), 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)), imm};
      step($urandom_range(7, 0) != 0, ord, 1'($urandom), 1'($urandom),
           ($urandom_range(1, 0) == 1) ? C_LW : 8'($urandom),
           $urandom_range(7, 0) == 0, $urandom_range(7, 0) == 0);
    end
    step(0, 32'h0, 0, 0, 8'h00, 0, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
